univ_shift_register: RTL

Parametrised universal shift register: the generalised successor to the team's fixed 4-bit parallel-in/parallel-out register. It adds configurable width, shift-left, shift-right, hold and parallel-load modes, serial ports at both ends, and a remaining-bit counter with an empty flag. It sits between parallel datapaths and serial links, and serves as a PIPO, SIPO, PISO or SISO stage depending on how `mode` is driven.

---
 rtl/univ_shift_register.sv | 83 ++++++++
 1 files changed

// File: rtl/univ_shift_register.sv
// Universal shift register: hold / shift right / shift left / parallel load, with a
// remaining-bit counter and registered empty flag. Optional UNIV_SREG_ROTATE_EN adds a `rot` input.
module univ_shift_register #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
`ifdef UNIV_SREG_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] parallel_out,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic [CW-1:0]    count,
  output logic             empty
);

  typedef enum logic [1:0] {
    M_HOLD  = 2'b00,
    M_SHR   = 2'b01,
    M_SHL   = 2'b10,
    M_LOAD  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [CW-1:0]    cnt_dec;
  logic             fill_r, fill_l;

  // Rotation just swaps the serial fill source for the bit falling off the other end.
`ifdef UNIV_SREG_ROTATE_EN
  assign fill_r = rot ? parallel_out[0]       : ser_in_r;
  assign fill_l = rot ? parallel_out[WIDTH-1] : ser_in_l;
`else
  assign fill_r = ser_in_r;
  assign fill_l = ser_in_l;
`endif

  assign cnt_dec   = (count == '0) ? '0 : count - CW'(1);
  assign ser_out_r = parallel_out[0];
  assign ser_out_l = parallel_out[WIDTH-1];

  always_comb begin
    q_nxt   = parallel_out;
    cnt_nxt = count;
    if (en) begin
      case (mode_e'(mode))
        M_SHR: begin
          q_nxt   = {fill_r, parallel_out[WIDTH-1:1]};
          cnt_nxt = cnt_dec;
        end
        M_SHL: begin
          q_nxt   = {parallel_out[WIDTH-2:0], fill_l};
          cnt_nxt = cnt_dec;
        end
        M_LOAD: begin
          q_nxt   = parallel_in;
          cnt_nxt = CW'(WIDTH);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      parallel_out <= '0;
      count        <= '0;
      empty        <= 1'b1;
    end else begin
      parallel_out <= q_nxt;
      count        <= cnt_nxt;
      empty        <= (cnt_nxt == '0);
    end
  end

endmodule
